// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//
// Two requesters share one combinational N-bit adder. A round-robin arbiter
// picks one requester per cycle and the chosen operand pair's sum, carry-out
// and signed overflow are captured in a single result register with a
// valid/ready handshake toward the consumer. A sticky overflow flag records
// any accepted pair that overflowed until software clears it.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_valid/a/b, req0_ready  requester 0 operand handshake
//   req1_valid/a/b, req1_ready  requester 1 operand handshake
//   rsp_valid, rsp_ready        result handshake
//   rsp_id                      index of the requester that produced the result
//   rsp_sum, rsp_cout, rsp_of   registered sum, carry-out, signed overflow
//   of_sticky, clr_of           sticky overflow flag and its synchronous clear
//
// Only N = 32 is supported.
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,

    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,

    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_of,
    input  logic         rsp_ready,

    output logic         of_sticky,
    input  logic         clr_of
);

    // Result register occupancy.
    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StFull  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic         last_gnt_q, last_gnt_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_sum_q, rsp_sum_d;
    logic         rsp_cout_q, rsp_cout_d;
    logic         rsp_of_q, rsp_of_d;
    logic         of_sticky_q, of_sticky_d;

    logic         gnt;
    logic         can_accept;
    logic         accept;
    logic [N-1:0] op_a, op_b;
    logic [N-1:0] add_sum;
    logic         add_cout;
    logic         add_of;

    // Arbitration looks only at the valids and the pointer, never at the
    // operand data, so the ready paths stay short.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = ~last_gnt_q;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end
    end

    assign can_accept = (state_q == StEmpty) || rsp_ready;

    // rst_n gates the readies so nothing is accepted while reset is held.
    assign req0_ready = rst_n && can_accept && !gnt && req0_valid;
    assign req1_ready = rst_n && can_accept &&  gnt && req1_valid;
    assign accept     = req0_ready || req1_ready;

    // The single shared adder, carry-in tied to zero.
    assign op_a = gnt ? req1_a : req0_a;
    assign op_b = gnt ? req1_b : req0_b;
    assign {add_cout, add_sum} = {1'b0, op_a} + {1'b0, op_b};
    assign add_of = (op_a[N-1] == op_b[N-1]) && (add_sum[N-1] != op_a[N-1]);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_of_d   = rsp_of_q;

        if (accept) begin
            last_gnt_d = gnt;
            rsp_id_d   = gnt;
            rsp_sum_d  = add_sum;
            rsp_cout_d = add_cout;
            rsp_of_d   = add_of;
        end

        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                // Consume with a new accept refills without a bubble.
                if (rsp_ready && !accept) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // An overflowing accept beats a simultaneous clear.
    assign of_sticky_d = (of_sticky_q && !clr_of) || (accept && add_of);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            last_gnt_q  <= 1'b1;    // requester 0 wins the first tie
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_of_q    <= 1'b0;
            of_sticky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_of_q    <= rsp_of_d;
            of_sticky_q <= of_sticky_d;
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_of    = rsp_of_q;
    assign of_sticky = of_sticky_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
//
// Directed checks of adder_share_arbiter: reset values, single add, carry and
// overflow, sticky flag and its clear, backpressure, tie alternation, async
// reset mid-stream, followed by a short randomized run against a small
// reference model. Inputs change on the falling edge; outputs are sampled
// on the falling edge or 1 time unit after inputs change.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_cout, rsp_of;
    logic [31:0] rsp_sum;
    logic        rsp_ready;
    logic        of_sticky;
    logic        clr_of;

    int n_tests = 0;
    int n_fail  = 0;

    adder_share_arbiter #(.N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_of     (rsp_of),
        .rsp_ready  (rsp_ready),
        .of_sticky  (of_sticky),
        .clr_of     (clr_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic v1, input logic [31:0] a1, input logic [31:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    // Registered response snapshot: {valid, id, cout, of, sticky, sum}.
    task automatic check_rsp(input string tag, input logic v, input logic id, input logic c,
                             input logic o, input logic st, input logic [31:0] s);
        check(tag, {27'd0, rsp_valid, rsp_id, rsp_cout, rsp_of, of_sticky, rsp_sum},
                   {27'd0, v, id, c, o, st, s});
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check(tag, {62'd0, req1_ready, req0_ready}, {62'd0, r1, r0});
    endtask

    // Reference model state for the random run.
    logic        m_valid, m_last, m_id, m_cout, m_of, m_sticky;
    logic [31:0] m_sum;

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0; clr_of = 1'b0;
        set_req(1'b1, 32'd1, 32'd1, 1'b1, 32'd2, 32'd2);

        // Reset: outputs at reset values, readies held low.
        #2;
        check_rsp("reset_outputs", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_rdy("reset_ready_low", 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_rdy("reset_ready_low_held", 1'b0, 1'b0);
        check_rsp("reset_no_accept", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Single add 5+3 from requester 0.
        rst_n = 1'b1; rsp_ready = 1'b1;
        set_req(1'b1, 32'd5, 32'd3, 1'b0, 32'd0, 32'd0);
        #1 check_rdy("single_ready", 1'b1, 1'b0);
        @(negedge clk);
        set_req(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        check_rsp("single_rsp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8);

        // Consume with no accept: valid drops, fields hold.
        @(negedge clk);
        check_rsp("consume_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8);

        // Carry out with no overflow from requester 1.
        set_req(1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1);
        #1 check_rdy("carry_ready", 1'b0, 1'b1);
        @(negedge clk);
        check_rsp("carry_rsp", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // Signed overflow sets the sticky flag.
        set_req(1'b0, 32'd0, 32'd0, 1'b1, 32'h7FFF_FFFF, 32'h1);
        @(negedge clk);
        check_rsp("ovf_rsp", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
        set_req(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_rsp("sticky_holds", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000);

        // Overflowing accept together with clr_of: sticky stays set.
        clr_of = 1'b1;
        set_req(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 32'd0);
        #1 check_rdy("neg_ovf_ready", 1'b1, 1'b0);
        @(negedge clk);
        check_rsp("ovf_beats_clr", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);

        // clr_of alone clears the sticky flag.
        set_req(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_rsp("clr_sticky", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        clr_of = 1'b0;

        // Backpressure: fill the slot, then stall 5 cycles with both valid.
        rsp_ready = 1'b0;
        set_req(1'b1, 32'h10, 32'h20, 1'b0, 32'd0, 32'd0);
        #1 check_rdy("fill_ready", 1'b1, 1'b0);
        @(negedge clk);
        check_rsp("fill_rsp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30);
        set_req(1'b1, 32'd1, 32'd1, 1'b1, 32'd2, 32'd2);
        for (int i = 0; i < 5; i++) begin
            #1 check_rdy("stall_ready", 1'b0, 1'b0);
            @(negedge clk);
            check_rsp("stall_rsp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30);
        end

        // Release: last grant was 0, so requester 1 goes first, then alternate.
        rsp_ready = 1'b1;
        #1 check_rdy("resume_ready1", 1'b0, 1'b1);
        @(negedge clk);
        check_rsp("resume_rsp1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4);
        #1 check_rdy("resume_ready0", 1'b1, 1'b0);
        @(negedge clk);
        check_rsp("resume_rsp0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2);
        #1 check_rdy("resume_ready1b", 1'b0, 1'b1);
        @(negedge clk);
        check_rsp("resume_rsp1b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4);
        set_req(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_rsp("drain", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4);

        // Reset mid-stream: requester 0 fills the slot (pointer -> 0), then
        // an async reset must clear the result and restore the pointer.
        set_req(1'b1, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_rsp("pre_reset_rsp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7);
        set_req(1'b1, 32'd3, 32'd4, 1'b1, 32'd5, 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check_rsp("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_rdy("async_reset_ready", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_rdy("post_reset_tie0", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                check_rsp("tie_rsp0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7);
                #1 check_rdy("tie_ready1", 1'b0, 1'b1);
            end else begin
                check_rsp("tie_rsp1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB);
                #1 check_rdy("tie_ready0", 1'b1, 1'b0);
            end
        end

        // Randomized run against a reference model, started from reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0; m_last = 1'b1; m_id = 1'b0; m_cout = 1'b0;
        m_of = 1'b0; m_sticky = 1'b0; m_sum = 32'h0;
        for (int i = 0; i < 400; i++) begin
            logic        v0, v1, g, can, e0, e1, acc, o;
            logic [31:0] a, b;
            logic [32:0] full;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            set_req(v0, $urandom, $urandom, v1, $urandom, $urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            clr_of    = ($urandom_range(0, 7) == 0);

            can = !m_valid || rsp_ready;
            g   = (v0 && v1) ? !m_last : v1;
            e0  = can && v0 && !g;
            e1  = can && v1 &&  g;
            acc = e0 || e1;
            a   = g ? req1_a : req0_a;
            b   = g ? req1_b : req0_b;
            full = {1'b0, a} + {1'b0, b};
            o   = (a[31] == b[31]) && (full[31] != a[31]);
            #1 check_rdy("rand_ready", e0, e1);

            m_sticky = (m_sticky && !clr_of) || (acc && o);
            if (acc) begin
                m_valid = 1'b1; m_last = g; m_id = g;
                m_sum = full[31:0]; m_cout = full[32]; m_of = o;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
            check_rsp("rand_rsp", m_valid, m_id, m_cout, m_of, m_sticky, m_sum);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 Parameter N SHALL default to 32 and give the operand/sum width; only N=32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  N each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same as REQ-004..006 for requester 1.
REQ-008 rsp_valid  output  1  result register holds an unconsumed result.
REQ-009 rsp_id  output  1  requester index that produced the result.
REQ-010 rsp_sum  output  N  registered a+b, modulo 2^N.
REQ-011 rsp_cout  output  1  registered carry out of bit N-1.
REQ-012 rsp_of  output  1  registered signed overflow: a[N-1]==b[N-1] and sum[N-1]!=a[N-1].
REQ-013 rsp_ready  input  1  consumer takes the result this cycle.
REQ-014 of_sticky  output  1  set by any accepted pair that overflows; held until cleared.
REQ-015 clr_of  input  1  synchronous clear of of_sticky.

Function
REQ-016 The block SHALL contain one shared combinational N-bit adder, carry-in fixed 0, fed by the granted requester's operands.
REQ-017 Slot free ("can_accept") SHALL be rsp_valid==0 or rsp_ready==1.
REQ-018 Grant: only one valid -> that requester; both valid -> requester not granted most recently (pointer last_gnt).
REQ-019 reqX_ready SHALL be combinational = can_accept and grant==X and reqX_valid; never both high in one cycle.
REQ-020 reqX_ready SHALL NOT depend on reqY_a/b data; it may depend on both valids, rsp_valid, rsp_ready, last_gnt.
REQ-021 On accept (valid and ready) the result register SHALL load sum, cout, of, id on the same edge; rsp_valid=1 next cycle (latency 1).
REQ-022 last_gnt SHALL update to the accepted index only on accept; otherwise hold.
REQ-023 If rsp_valid=1 and rsp_ready=0, rsp_* SHALL hold stable and no request SHALL be accepted.
REQ-024 Consume and accept in the same cycle SHALL replace the result with no bubble (throughput 1 result/cycle).
REQ-025 Consume with no accept SHALL clear rsp_valid next cycle; rsp_sum/cout/of/id hold last values.
REQ-026 Effective states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); EMPTY->FULL on accept; FULL->EMPTY on consume without accept; FULL->FULL on consume with accept or stall.
REQ-027 of_sticky next = (of_sticky and not clr_of) or (accept and overflow); accept with overflow wins over simultaneous clr_of.
REQ-028 A requester dropping valid without acceptance SHALL not change last_gnt or any output register.

Reset
REQ-029 rst_n low SHALL immediately force rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_of=0, of_sticky=0, last_gnt=1 (requester 0 wins first tie).
REQ-030 reqX_ready SHALL be 0 while rst_n is low; reset mid-transfer SHALL discard the held result.
REQ-031 First accept SHALL occur no earlier than the first rising clk after rst_n deasserts.

Verification
REQ-032 Single add: req0 a=0x0000_0005 b=0x0000_0003, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0x8, cout=0, of=0, id=0.
REQ-033 Carry/overflow: req1 a=0xFFFF_FFFF b=0x1 -> sum=0, cout=1, of=0; a=0x7FFF_FFFF b=0x1 -> sum=0x8000_0000, of=1, of_sticky=1 until clr_of.
REQ-034 Tie fairness: both valid continuously, rsp_ready=1, after reset -> grants 0,1,0,1..., one rsp per cycle, rsp_id alternating.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles with both valid -> both ready=0, rsp_* stable; rsp_ready=1 -> accept resumes same cycle, no result lost or duplicated.
REQ-036 Reset mid-stream: assert rst_n low while rsp_valid=1 -> outputs to REQ-029 values asynchronously; first post-reset tie goes to requester 0.
REQ-037 Random: 10k random operands/valids/rsp_ready vs scoreboard (mod 2^32 sum, cout, signed of, in-order per id) -> zero mismatches, no starvation beyond 1 grant.
